// File: rtl/norm_pkg.sv
// Shared definitions for the normalizer: default widths, a clog2 helper and
// the rule that the count width must be able to hold the value DATA_W.
package norm_pkg;

    localparam int NORM_DATA_W  = 8;
    localparam int NORM_COUNT_W = 4;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // True when 2^cw > dw, i.e. a count of dw leading zeros fits in cw bits.
    function automatic bit count_w_fits(input int dw, input int cw);
        return (longint'(1) << cw) > longint'(dw);
    endfunction

    localparam bit NORM_DEFAULTS_OK = count_w_fits(NORM_DATA_W, NORM_COUNT_W);

endpackage

// File: rtl/lz_count.sv
// Combinational MSB-first leading-zero counter; an all-zero word yields DATA_W.
module lz_count
    import norm_pkg::*;
#(
    parameter int DATA_W  = NORM_DATA_W,
    parameter int COUNT_W = NORM_COUNT_W
) (
    input  logic [DATA_W-1:0]  data,
    output logic [COUNT_W-1:0] count
);

    logic found;

    // Scan from the MSB; the first 1 encountered fixes the count.
    always_comb begin
        count = COUNT_W'(DATA_W);
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found && data[i]) begin
                count = COUNT_W'(DATA_W - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/normalizer.sv
// Two-stage normalizer: S1 captures the word and its leading-zero count,
// S2 holds the left-shifted word, the shift amount and an all-zero flag.
module normalizer
    import norm_pkg::*;
#(
    parameter int DATA_W  = NORM_DATA_W,
    parameter int COUNT_W = NORM_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [COUNT_W-1:0] out_shift,
    output logic               out_zero
);

    localparam int SH_W = clog2(DATA_W);
    localparam logic [COUNT_W-1:0] LZ_ALL = COUNT_W'(DATA_W);

    if (DATA_W < 2 || !count_w_fits(DATA_W, COUNT_W)) begin : g_bad_params
        $error("normalizer: need DATA_W >= 2 and 2**COUNT_W > DATA_W");
    end

    logic [COUNT_W-1:0] lz;

    logic               s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]  s1_data_q, s1_data_d;
    logic [COUNT_W-1:0] s1_lz_q, s1_lz_d;
    logic               s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]  s2_data_q, s2_data_d;
    logic [COUNT_W-1:0] s2_shift_q, s2_shift_d;
    logic               s2_zero_q, s2_zero_d;

    logic               s1_load, s2_load;
    logic [DATA_W-1:0]  s1_shifted;

    lz_count #(
        .DATA_W  (DATA_W),
        .COUNT_W (COUNT_W)
    ) u_lz_count (
        .data  (in_data),
        .count (lz)
    );

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load && !rst;

    // Only the low bits of lz steer the shifter; the all-zero case is forced to 0.
    assign s1_shifted = (s1_lz_q < LZ_ALL) ? (s1_data_q << s1_lz_q[SH_W-1:0]) : '0;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_lz_d    = s1_lz_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_shift_d = s2_shift_q;
        s2_zero_d  = s2_zero_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_lz_d   = lz;
            end
        end

        // Bubbles leave the S2 payload untouched so the last word's outputs stay put.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d  = s1_shifted;
                s2_shift_d = s1_lz_q;
                s2_zero_d  = (s1_lz_q == LZ_ALL);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_lz_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_shift_q <= '0;
            s2_zero_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_lz_q    <= s1_lz_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_shift_q <= s2_shift_d;
            s2_zero_q  <= s2_zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_shift = s2_shift_q;
    assign out_zero  = s2_zero_q;

endmodule

// File: tb/tb_normalizer.sv
// Scoreboard bench for normalizer: accepted words push a reference result,
// a monitor pops and compares on every output transfer.
module tb_normalizer;

    localparam int DATA_W  = 8;
    localparam int COUNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [COUNT_W-1:0] out_shift;
    logic               out_zero;

    typedef struct {
        logic [DATA_W-1:0]  data;
        logic [COUNT_W-1:0] shift;
        logic               zero;
    } exp_t;

    exp_t expq[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic               held_valid = 1'b0;
    logic [DATA_W-1:0]  held_data;
    logic [COUNT_W-1:0] held_shift;
    logic               held_zero;

    normalizer #(
        .DATA_W  (DATA_W),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Reference: leading zeros = width minus the bit length of the word.
    function automatic exp_t refModel(input logic [DATA_W-1:0] w);
        exp_t e;
        int   lz;
        lz      = DATA_W - $clog2(int'(w) + 1);
        e.shift = COUNT_W'(lz);
        e.zero  = (w == 0);
        e.data  = DATA_W'((int'(w) * (1 << lz)) % (1 << DATA_W));
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Offers one word and returns one cycle after it is accepted (bounded wait).
    task automatic applyStimulus(input logic [DATA_W-1:0] w);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = w;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL accept_timeout: word %0h not accepted", w);
                break;
            end
        end
        stepCycle();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) expq.push_back(refModel(in_data));
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            expq.delete();
            held_valid = 1'b0;
        end else begin
            if (held_valid)
                checkOutput("hold_stable", {out_valid, out_data, out_shift, out_zero},
                            {1'b1, held_data, held_shift, held_zero});
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_output: got data %0h shift %0d with empty queue",
                             out_data, out_shift);
                end else begin
                    e = expq.pop_front();
                    checkOutput("output_word", {out_data, out_shift, out_zero},
                                {e.data, e.shift, e.zero});
                end
            end
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            held_shift = out_shift;
            held_zero  = out_zero;
        end
    end

    initial begin
        int sent;
        int cycles;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("reset_outputs", {out_valid, out_data, out_shift, out_zero}, 32'd0);
        stepCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", {31'b0, in_ready}, 32'd1);
        stepCycle();

        // Single word latency and pulse width.
        applyStimulus(8'h16);
        @(negedge clk);
        checkOutput("latency_s1_only", {31'b0, out_valid}, 32'd0);
        stepCycle();
        @(negedge clk);
        checkOutput("latency_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("latency_word", {out_data, out_shift, out_zero}, {8'hB0, 4'd3, 1'b0});
        stepCycle();
        @(negedge clk);
        checkOutput("single_pulse", {31'b0, out_valid}, 32'd0);
        stepCycle();

        // Boundary words, then a back-to-back stream.
        applyStimulus(8'h00);
        applyStimulus(8'h80);
        applyStimulus(8'h01);
        applyStimulus(8'hFF);
        repeat (3) stepCycle();
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h04);
        applyStimulus(8'h08);
        repeat (4) stepCycle();

        // Backpressure: two words fill the pipe, the third waits for release.
        out_ready = 1'b0;
        applyStimulus(8'h10);
        applyStimulus(8'h20);
        in_valid = 1'b1;
        in_data  = 8'h40;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
            if (i == 0)
                checkOutput("stall_front", {out_valid, out_data, out_shift}, {1'b1, 8'h80, 4'd3});
            stepCycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_accept", {31'b0, in_ready}, 32'd1);
        stepCycle();
        in_valid = 1'b0;
        repeat (4) stepCycle();

        // Reset with both stages occupied.
        out_ready = 1'b0;
        applyStimulus(8'h03);
        applyStimulus(8'h05);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_in_ready", {31'b0, in_ready}, 32'd0);
        stepCycle();
        @(negedge clk);
        checkOutput("reset_mid_outputs", {out_valid, out_data, out_shift, out_zero}, 32'd0);
        stepCycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_ready", {31'b0, in_ready}, 32'd1);
        repeat (5) stepCycle();

        // Randomized traffic with random valid and backpressure.
        sent   = 0;
        cycles = 0;
        while (sent < 1000 && cycles < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       in_data = '0;
                1:       in_data = DATA_W'(1) << $urandom_range(0, DATA_W - 1);
                default: in_data = DATA_W'($urandom);
            endcase
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            stepCycle();
            cycles++;
        end
        checkOutput("random_sent", sent, 32'd1000);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && expq.size() != 0; i++) stepCycle();
        repeat (2) stepCycle();
        checkOutput("drain_empty", expq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/normalizer.md
# normalizer

Streaming normalization stage placed directly downstream of leading-zero counting. Accepts DATA_W-bit words on a valid/ready interface and computes the number of leading zeros (MSB-first). Shifts each word left by that count so its MSB is 1, and emits the normalized word with the shift amount and an all-zero flag. Two-stage registered pipeline with full throughput and backpressure.

## Interface
- DATA_W, 8: data word width; must be ≥ 2.
- COUNT_W, 4: shift-count width; must satisfy 2^COUNT_W > DATA_W so that the value DATA_W is representable.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input word present.
- in_ready  out  1  stage can accept a word this cycle.
- in_data  in  DATA_W  input word.
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts the output this cycle.
- out_data  out  DATA_W  normalized word.
- out_shift  out  COUNT_W  leading-zero count of the source word.
- out_zero  out  1  source word was all zeros.

## Operation
- The input transfer occurs on a cycle with in_valid && in_ready. The output transfer occurs on a cycle with out_valid && out_ready.
- Stage 1 (S1) registers in_data and its leading-zero count lz, computed combinationally from in_data.
  - lz counts consecutive zeros from bit DATA_W-1 downward.
  - Zeros after the first 1 are not counted.
  - lz is in the range 0..DATA_W.
- Stage 2 (S2) registers three results:
  - out_data = S1 data << lz, zero-filled from the LSB, when lz < DATA_W; otherwise 0.
  - out_shift = lz.
  - out_zero = (lz == DATA_W).
- For a non-zero input, out_data[DATA_W-1] is always 1.
- Each stage has a valid bit. A stage advances when it is empty or when its downstream consumes it this cycle:
  - S2 loads when !S2_valid || out_ready.
  - S1 loads when !S1_valid || S2 loads.
  - in_ready = S1 loads, and is forced to 0 while rst is high.
- Words leave in acceptance order. None are dropped or duplicated.
- While out_valid && !out_ready, the out_data, out_shift and out_zero outputs are held stable.
- Reset, including mid-stream, clears both valid bits and all output registers. In-flight words are discarded.

## Timing
- Reset values: out_valid=0, out_data=0, out_shift=0, out_zero=0, in_ready=0 during reset. in_ready=1 in the first cycle after rst deasserts.
- Latency: a word accepted at edge N is presented at edge N+2 when out_ready stays high.
- Throughput: one word per cycle with no bubbles while out_ready=1.
- Stall: with out_ready held low, the pipeline absorbs exactly two words, then in_ready drops combinationally in the same cycle.
- in_ready may depend combinationally on out_ready. in_ready must not depend on in_valid.
- A simultaneous output transfer and input accept on a full pipeline shifts both stages with no bubble.
- COUNT_W arithmetic: lz is built at COUNT_W width with no overflow, given the parameter rule above. The shift uses the low bits of lz only when lz < DATA_W.

## Structure
- Shared package norm_pkg holds:
  - a clog2 function;
  - default DATA_W and COUNT_W localparams;
  - an elaboration-time check of 2^COUNT_W > DATA_W.
- One sub-module is natural: lz_count, a parameterized combinational MSB-first leading-zero counter. Ports are data [DATA_W-1:0] and count [COUNT_W-1:0]. It is instantiated once between in_data and S1.
- The shifter and handshake control stay in the top module.

## Test plan
- 8'h16 (00010110) accepted, out_ready=1:
  - 2 cycles later out_data=8'hB0, out_shift=3, out_zero=0, out_valid=1 for 1 cycle.
- Boundary words, each in its own cycle:
  - 8'h00 gives out_data=8'h00, out_shift=8, out_zero=1.
  - 8'h80 gives 8'h80, shift=0.
  - 8'h01 gives 8'h80, shift=7.
  - 8'hFF gives 8'hFF, shift=0.
- Back-to-back stream 8'h01, 8'h02, 8'h04, 8'h08 on consecutive cycles, out_ready=1:
  - outputs on 4 consecutive cycles, all with out_data=8'h80;
  - shifts in order 7, 6, 5, 4.
- Backpressure: out_ready=0 for 5 cycles while offering 8'h10, 8'h20, 8'h40:
  - in_ready drops after 2 accepts;
  - out_data=8'h80, shift=3 is held stable for the whole stall;
  - after out_ready=1, the outputs are shift 3, 2, 1 in order, and 8'h40 is accepted on the first release cycle.
- Reset mid-stream with both stages valid:
  - the cycle after rst, out_valid=0 and all outputs are 0;
  - no stale word appears afterwards;
  - in_ready=1 once rst is low.
- Randomized words against a reference leading-zero and shift model:
  - 1000 words with random in_valid and out_ready;
  - ordering and values match the model, and there is no loss or duplication.
